// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//   Groups the signals of the memory-access sequencer. The interface carries
//   three sets of signals: the EX/MEM decode fields, the data-memory port,
//   and the pipeline-control outputs.
//
// Handshake: mem_req is asserted from the first WAIT cycle and held until
// mem_ready is seen high in WAIT (or the wait times out). mem_we/mem_size are
// stable for as long as mem_req is high. mem_ready is only meaningful while
// mem_req is high; at any other time it is ignored.
//
// Ports (per modport):
//   master : the controller. It has these inputs:
//              memread, memwrite, addr_lo, mem_ready
//            It drives these outputs:
//              mem_req, mem_we, mem_size, stall, wb_bubble,
//              align_err, timeout_err, wait_cnt
//   slave  : the environment (pipeline + data memory), with each direction
//            reversed.
interface mem_access_ctrl_if #(
  parameter int CNT_W = 5
);
  logic [1:0]       memread;
  logic [1:0]       memwrite;
  logic [1:0]       addr_lo;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic             stall;
  logic             wb_bubble;
  logic             align_err;
  logic             timeout_err;
  logic [CNT_W-1:0] wait_cnt;

  modport master (
    input  memread, memwrite, addr_lo, mem_ready,
    output mem_req, mem_we, mem_size, stall, wb_bubble,
           align_err, timeout_err, wait_cnt
  );

  modport slave (
    output memread, memwrite, addr_lo, mem_ready,
    input  mem_req, mem_we, mem_size, stall, wb_bubble,
           align_err, timeout_err, wait_cnt
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences the data-memory access of the instruction held in EX/MEM. It
//   decodes the memread/memwrite fields and checks alignment. It then issues
//   a registered request and stalls the front of the pipeline until the memory
//   answers or TIMEOUT WAIT cycles pass. While the access is outstanding it
//   bubbles MEM/WB.
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous, active-high reset
//   bus        mem_access_ctrl_if.master (decode fields, memory port,
//              stall / wb_bubble / error pulses / wait_cnt)
//   dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_ctrl_if.master    bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // wait_cnt value on the last WAIT cycle before abort
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [1:0]       mem_size_q, mem_size_d;
  logic             align_err_q, align_err_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic             access;
  logic             eff_we;
  logic [1:0]       eff_size;
  logic             aligned;
  logic             stall;
  logic             wb_bubble;

  // Decode: when both fields are set the write wins, and alignment is
  // checked against the size that will actually be issued.
  always_comb begin
    access   = (bus.memread != 2'b00) || (bus.memwrite != 2'b00);
    eff_we   = (bus.memwrite != 2'b00);
    eff_size = eff_we ? bus.memwrite : bus.memread;
    case (eff_size)
      2'b10:   aligned = ~bus.addr_lo[0];
      2'b11:   aligned = (bus.addr_lo == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_size_d    = mem_size_q;
    align_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    wait_cnt_d    = wait_cnt_q;
    stall         = 1'b0;
    wb_bubble     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_size_d = 2'b00;
        if (access) begin
          wb_bubble = 1'b1;
          if (aligned) begin
            stall      = 1'b1;
            state_d    = ST_WAIT;
            mem_req_d  = 1'b1;
            mem_we_d   = eff_we;
            mem_size_d = eff_size;
            wait_cnt_d = '0;
          end else begin
            // Misaligned: the instruction is killed without a request.
            align_err_d = 1'b1;
          end
        end
      end

      ST_WAIT: begin
        stall     = 1'b1;
        wb_bubble = 1'b1;
        if (bus.mem_ready || (wait_cnt_q == LAST_CNT)) begin
          // Ready on the final cycle still counts as success.
          timeout_err_d = ~bus.mem_ready;
          state_d       = ST_DONE;
          mem_req_d     = 1'b0;
          mem_we_d      = 1'b0;
          mem_size_d    = 2'b00;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_size_d = 2'b00;
      end

      default: begin
        state_d    = ST_IDLE;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_size_d = 2'b00;
      end
    endcase

    // The pipeline must never be held or bubbled while in reset.
    if (rst) begin
      stall     = 1'b0;
      wb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_size_q    <= 2'b00;
      align_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_size_q    <= mem_size_d;
      align_err_q   <= align_err_d;
      timeout_err_q <= timeout_err_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_size    = mem_size_q;
  assign bus.align_err   = align_err_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.wait_cnt    = wait_cnt_q;
  assign bus.stall       = stall;
  assign bus.wb_bubble   = wb_bubble;
  assign dbg_state       = state_q;

endmodule
